branch_target_buffer: RTL and testbench

- Fully associative branch target buffer that answers the IF-stage lookup and sends `FindinBTB`, `taken` and the predicted target to the PC mux.
- Carries the lookup result into the ID stage alongside the fetched PC.
- Consumes the `WriteEntry` update code that the ID-stage next-address logic returns (allocate on miss, retrain on misprediction).
- Supplies the stage-2 PC and its sequential successor for misprediction recovery.

---
 rtl/branch_target_buffer.sv | 160 ++++++++++++++++
 tb/tb_branch_target_buffer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// Fully associative branch target buffer with a stage-2 register for the ID stage.
// Define BTB_2BIT_COUNTER_EN for 2-bit hysteresis counters; otherwise each entry keeps a 1-bit direction.
module branch_target_buffer #(
    parameter int ENTRIES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_IF,
    input  logic        Pipe_stall,
    input  logic [2:0]  WriteEntry,
    input  logic        Branch_taken,
    input  logic [31:0] BranchTarget,
    output logic        FindinBTB,
    output logic        taken,
    output logic [31:0] PredTarget,
    output logic        FindinBTB_S2,
    output logic        taken_S2,
    output logic [31:0] PC_Stage2,
    output logic [31:0] PC_Stage2_plus4
);

    localparam int IDXW = $clog2(ENTRIES);
`ifdef BTB_2BIT_COUNTER_EN
    localparam int CTRW = 2;
`else
    localparam int CTRW = 1;
`endif

    logic            valid_q  [ENTRIES];
    logic            valid_d  [ENTRIES];
    logic [29:0]     tag_q    [ENTRIES];
    logic [29:0]     tag_d    [ENTRIES];
    logic [31:0]     target_q [ENTRIES];
    logic [31:0]     target_d [ENTRIES];
    logic [CTRW-1:0] ctr_q    [ENTRIES];
    logic [CTRW-1:0] ctr_d    [ENTRIES];
    logic [IDXW-1:0] repl_q, repl_d;

    logic [31:0]     pc_s2_q;
    logic            hit_s2_q;
    logic [IDXW-1:0] idx_s2_q;
    logic            taken_s2_q;

    logic [ENTRIES-1:0] lookup_match;
    logic [ENTRIES-1:0] s2_match;
    logic [ENTRIES-1:0] free_vec;
    logic [IDXW-1:0]    hit_idx;
    logic [IDXW-1:0]    wr_idx;
    logic               retrain_ok;

    // The direction bit is never used to index or tag the table.
    logic unused_wr_bit2;
    assign unused_wr_bit2 = WriteEntry[2];

    // Lowest set index; callers only use the result when the vector is non-zero.
    function automatic logic [IDXW-1:0] first_set(input logic [ENTRIES-1:0] v);
        logic [IDXW-1:0] r;
        r = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (v[i]) r = IDXW'(i);
        end
        return r;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            assign lookup_match[gi] = valid_q[gi] && (tag_q[gi] == PC_IF[31:2]);
            assign s2_match[gi]     = valid_q[gi] && (tag_q[gi] == pc_s2_q[31:2]);
            assign free_vec[gi]     = ~valid_q[gi];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    valid_q[gi]  <= 1'b0;
                    tag_q[gi]    <= '0;
                    target_q[gi] <= '0;
                    ctr_q[gi]    <= '0;
                end else begin
                    valid_q[gi]  <= valid_d[gi];
                    tag_q[gi]    <= tag_d[gi];
                    target_q[gi] <= target_d[gi];
                    ctr_q[gi]    <= ctr_d[gi];
                end
            end
        end
    endgenerate

    // Lookup reads only registered table state, so an update lands one cycle later.
    assign hit_idx    = first_set(lookup_match);
    assign FindinBTB  = |lookup_match;
    assign taken      = FindinBTB & ctr_q[hit_idx][CTRW-1];
    assign PredTarget = FindinBTB ? target_q[hit_idx] : 32'd0;

    assign retrain_ok = valid_q[idx_s2_q] && (tag_q[idx_s2_q] == pc_s2_q[31:2]);

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        repl_d   = repl_q;
        wr_idx   = '0;
        if (!Pipe_stall) begin
            if (WriteEntry[1]) begin
                // Rewriting an existing copy keeps a PC from ever occupying two entries.
                if (|s2_match) begin
                    wr_idx = first_set(s2_match);
                end else if (|free_vec) begin
                    wr_idx = first_set(free_vec);
                end else begin
                    wr_idx = repl_q;
                    repl_d = repl_q + 1'b1;
                end
                valid_d[wr_idx]  = 1'b1;
                tag_d[wr_idx]    = pc_s2_q[31:2];
                target_d[wr_idx] = BranchTarget;
`ifdef BTB_2BIT_COUNTER_EN
                ctr_d[wr_idx]    = Branch_taken ? 2'b10 : 2'b01;
`else
                ctr_d[wr_idx]    = Branch_taken;
`endif
            end else if (WriteEntry[0] && retrain_ok) begin
`ifdef BTB_2BIT_COUNTER_EN
                if (Branch_taken) begin
                    if (ctr_q[idx_s2_q] != 2'b11) ctr_d[idx_s2_q] = ctr_q[idx_s2_q] + 2'b01;
                end else begin
                    if (ctr_q[idx_s2_q] != 2'b00) ctr_d[idx_s2_q] = ctr_q[idx_s2_q] - 2'b01;
                end
`else
                ctr_d[idx_s2_q] = Branch_taken;
`endif
                if (Branch_taken) target_d[idx_s2_q] = BranchTarget;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            repl_q     <= '0;
            pc_s2_q    <= '0;
            hit_s2_q   <= 1'b0;
            idx_s2_q   <= '0;
            taken_s2_q <= 1'b0;
        end else begin
            repl_q <= repl_d;
            if (!Pipe_stall) begin
                pc_s2_q    <= PC_IF;
                hit_s2_q   <= FindinBTB;
                idx_s2_q   <= hit_idx;
                taken_s2_q <= taken;
            end
        end
    end

    assign FindinBTB_S2    = hit_s2_q;
    assign taken_S2        = taken_s2_q;
    assign PC_Stage2       = pc_s2_q;
    assign PC_Stage2_plus4 = pc_s2_q + 32'd4;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed and randomized bench for branch_target_buffer against an abstract table model.
module tb_branch_target_buffer;
    localparam int N = 8;
`ifdef BTB_2BIT_COUNTER_EN
    localparam int CMAX = 3;
`else
    localparam int CMAX = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PC_IF;
    logic        Pipe_stall;
    logic [2:0]  WriteEntry;
    logic        Branch_taken;
    logic [31:0] BranchTarget;
    logic        FindinBTB, taken, FindinBTB_S2, taken_S2;
    logic [31:0] PredTarget, PC_Stage2, PC_Stage2_plus4;

    int total = 0;
    int bad   = 0;

    branch_target_buffer #(.ENTRIES(N)) dut (
        .clk(clk), .reset(reset), .PC_IF(PC_IF), .Pipe_stall(Pipe_stall),
        .WriteEntry(WriteEntry), .Branch_taken(Branch_taken), .BranchTarget(BranchTarget),
        .FindinBTB(FindinBTB), .taken(taken), .PredTarget(PredTarget),
        .FindinBTB_S2(FindinBTB_S2), .taken_S2(taken_S2),
        .PC_Stage2(PC_Stage2), .PC_Stage2_plus4(PC_Stage2_plus4)
    );

    always #5 clk = ~clk;

    // Model: the table as plain arrays, counters as integers.
    bit          m_valid [N];
    logic [29:0] m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];
    int          m_repl;
    logic [31:0] m_s2_pc;
    bit          m_s2_hit;
    int          m_s2_idx;
    bit          m_s2_taken;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mclear();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 0;
        end
        m_repl = 0; m_s2_pc = '0; m_s2_hit = 0; m_s2_idx = 0; m_s2_taken = 0;
    endtask

    task automatic mlook(input logic [31:0] pc, output bit h, output int idx);
        h = 0; idx = 0;
        for (int i = 0; i < N; i++) begin
            if (!h && m_valid[i] && m_tag[i] == pc[31:2]) begin
                h = 1; idx = i;
            end
        end
    endtask

    task automatic mupdate();
        int idx;
        if (WriteEntry[1]) begin
            idx = -1;
            for (int i = 0; i < N; i++)
                if (idx < 0 && m_valid[i] && m_tag[i] == m_s2_pc[31:2]) idx = i;
            for (int i = 0; i < N; i++)
                if (idx < 0 && !m_valid[i]) idx = i;
            if (idx < 0) begin
                idx = m_repl;
                m_repl = (m_repl + 1) % N;
            end
            m_valid[idx] = 1;
            m_tag[idx]   = m_s2_pc[31:2];
            m_tgt[idx]   = BranchTarget;
            m_ctr[idx]   = Branch_taken ? (CMAX + 1) / 2 : (CMAX - 1) / 2;
        end else if (WriteEntry[0]) begin
            idx = m_s2_idx;
            if (m_valid[idx] && m_tag[idx] == m_s2_pc[31:2]) begin
                if (Branch_taken) begin
                    m_ctr[idx] = (m_ctr[idx] < CMAX) ? m_ctr[idx] + 1 : CMAX;
                    m_tgt[idx] = BranchTarget;
                end else begin
                    m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        bit h; int idx;
        mlook(PC_IF, h, idx);
        chk("FindinBTB", FindinBTB, h);
        chk("taken", taken, h ? (m_ctr[idx] > CMAX / 2) : 0);
        chk("PredTarget", PredTarget, h ? m_tgt[idx] : 32'd0);
        chk("FindinBTB_S2", FindinBTB_S2, m_s2_hit);
        chk("taken_S2", taken_S2, m_s2_taken);
        chk("PC_Stage2", PC_Stage2, m_s2_pc);
        chk("PC_Stage2_plus4", PC_Stage2_plus4, m_s2_pc + 32'd4);
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        bit h; int idx; bit tk; logic [31:0] pc;
        @(negedge clk);
        if (!reset) mclear();
        compare_all();
        mlook(PC_IF, h, idx);
        tk = h && (m_ctr[idx] > CMAX / 2);
        pc = PC_IF;
        @(posedge clk);
        if (reset && !Pipe_stall) begin
            mupdate();
            m_s2_pc = pc; m_s2_hit = h; m_s2_idx = h ? idx : 0; m_s2_taken = tk;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 0; WriteEntry = 3'b000; Pipe_stall = 0;
        cycle(); cycle();
        reset = 1;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish within budget");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        int r;
        logic [31:0] pc_r;
        reset = 0; PC_IF = '0; Pipe_stall = 0; WriteEntry = '0;
        Branch_taken = 0; BranchTarget = '0;
        mclear();
        repeat (2) cycle();
        chk("rst_find", FindinBTB, 0);
        chk("rst_plus4", PC_Stage2_plus4, 32'h4);
        reset = 1;

        // Reset lookup and stage-2 latency.
        PC_IF = 32'h40; #1;
        chk("t1_find", FindinBTB, 0);
        chk("t1_taken", taken, 0);
        chk("t1_pred", PredTarget, 0);
        cycle();
        chk("t1_pcs2", PC_Stage2, 32'h40);
        chk("t1_plus4", PC_Stage2_plus4, 32'h44);

        // Allocate taken branch at 0x40.
        WriteEntry = 3'b010; Branch_taken = 1; BranchTarget = 32'h100;
        cycle();
        WriteEntry = 3'b000; #1;
        chk("t2_find", FindinBTB, 1);
        chk("t2_taken", taken, 1);
        chk("t2_pred", PredTarget, 32'h100);
        cycle();

        // Retrain toward not-taken, then check saturation at the bottom.
        WriteEntry = 3'b001; Branch_taken = 0;
        cycle(); #1;
        chk("t3_taken_a", taken, 0);
        cycle(); #1;
        chk("t3_taken_b", taken, 0);
        cycle();
        Branch_taken = 1; BranchTarget = 32'h140;
        cycle();
        WriteEntry = 3'b000; #1;
`ifdef BTB_2BIT_COUNTER_EN
        chk("t3_taken_sat", taken, 0);
`else
        chk("t3_taken_sat", taken, 1);
`endif
        chk("t3_pred", PredTarget, 32'h140);
        cycle();

        // Fill all entries, then force a replacement of entry 0.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            PC_IF = (k < 8) ? k * 4 : ((k == 8) ? 32'h80 : 32'h04);
            WriteEntry = (k > 0) ? 3'b010 : 3'b000;
            Branch_taken = 1; BranchTarget = 32'h1000 + k;
            cycle();
        end
        WriteEntry = 3'b000;
        PC_IF = 32'h00; #1; chk("t4_old_miss", FindinBTB, 0);
        PC_IF = 32'h80; #1; chk("t4_new_hit", FindinBTB, 1); chk("t4_new_pred", PredTarget, 32'h1009);
        PC_IF = 32'h04; #1; chk("t4_e1_pred", PredTarget, 32'h1002);
        cycle();

        // Stall blocks both the update and the stage-2 capture.
        PC_IF = 32'h300; cycle();
        Pipe_stall = 1; WriteEntry = 3'b010; Branch_taken = 1; BranchTarget = 32'hDEAD;
        PC_IF = 32'h200;
        repeat (3) begin
            cycle(); #1;
            chk("t5_pcs2_hold", PC_Stage2, 32'h300);
        end
        Pipe_stall = 0; WriteEntry = 3'b000; PC_IF = 32'h300; #1;
        chk("t5_no_alloc", FindinBTB, 0);
        cycle();

        // Back-to-back allocate of the same PC must reuse one entry.
        PC_IF = 32'h40; cycle();
        WriteEntry = 3'b010; BranchTarget = 32'h500; cycle();
        BranchTarget = 32'h600; cycle();
        WriteEntry = 3'b000; #1;
        chk("t6_find", FindinBTB, 1);
        chk("t6_pred", PredTarget, 32'h600);
        PC_IF = 32'h08; #1; chk("t6_e2_kept", PredTarget, 32'h1003);
        PC_IF = 32'h04; #1; chk("t6_e1_gone", FindinBTB, 0);
        cnt = 0;
        for (int i = 0; i < N; i++) if (m_valid[i] && m_tag[i] == 30'h10) cnt++;
        chk("t6_model_one_copy", cnt, 1);
        cycle();

        // Reset landing on an allocate edge leaves the table empty.
        PC_IF = 32'h08; WriteEntry = 3'b010; BranchTarget = 32'h777;
        @(negedge clk);
        reset = 0; #1;
        chk("rmid_find", FindinBTB, 0);
        mclear();
        @(posedge clk); #1;
        reset = 1; WriteEntry = 3'b000; #1;
        chk("rmid_after", FindinBTB, 0);
        PC_IF = 32'h40; #1;
        chk("rmid_after40", FindinBTB, 0);
        chk("rmid_plus4", PC_Stage2_plus4, 32'h4);
        cycle();

        // Randomized traffic over a small PC pool so tags collide and the table churns.
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 11);
            pc_r = ((r % 2) ? 32'h8000_0000 : 32'h0) | 32'h1000 | (r << 2) | $urandom_range(0, 3);
            PC_IF = pc_r;
            Pipe_stall = ($urandom_range(0, 7) == 0);
            Branch_taken = $urandom_range(0, 1);
            BranchTarget = $urandom;
            r = $urandom_range(0, 9);
            if (r >= 4 && r <= 6)      WriteEntry[1:0] = {1'b1, 1'($urandom_range(0, 1))};
            else if (r >= 7 && r <= 8) WriteEntry[1:0] = m_s2_hit ? 2'b01 : 2'b00;
            else                       WriteEntry[1:0] = 2'b00;
            WriteEntry[2] = $urandom_range(0, 1);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
